hwpe_stream_tcdm_responder: RTL
===============================

Name: hwpe_stream_tcdm_responder

Overview:
Multi-port TCDM responder: the memory end of the hwpe_stream_intf_tcdm protocol, terminating NB_CHAN slave channels into NB_BANKS word-interleaved flop-based banks. Used as a behavioural/synthesizable scratch memory behind HWPE-Mem masters (streamers, reorder, mux blocks) in unit benches and small integrations. Per-bank round-robin arbitration, same-cycle gnt, fixed-latency r_valid/r_data.

Parameters:
NB_CHAN, 2, number of incoming HWPE-Mem channels (>=1).
NB_BANKS, 4, number of banks; power of 2, >=1.
NB_WORDS, 64, 32-bit words per bank; power of 2.
LATENCY, 1, cycles from granted request to r_valid; >=1.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
clear_i  in  1  synchronous clear: arbiters and response pipeline only.
in  slave  hwpe_stream_intf_tcdm [NB_CHAN-1:0]  req, add[31:0], we_n, be[3:0], data[31:0] in; gnt, r_data[31:0], r_valid out.

Behaviour:
- Clock/reset: single clock clk_i; reset rst_ni asynchronous, active-low.
- Address map: add[1:0] ignored; bank = add[2 +: log2(NB_BANKS)]; row = next log2(NB_WORDS) bits; higher bits ignored (aliasing/wrap). NB_BANKS=1 -> bank field zero-width, bank 0.
- we_n=0 write, we_n=1 read.
- Arbitration per bank, combinational: among channels with req=1 targeting bank b, one winner chosen round-robin; gnt=1 to winner only, same cycle. A channel not targeting any contending bank gets gnt=req. gnt never asserted without req.
- RR pointer per bank: after a grant to channel k, pointer <= (k+1) mod NB_CHAN; search from pointer upward with wrap. Pointer unchanged if no request to that bank. Reset/clear: 0 (channel 0 highest priority).
- Write on grant: at posedge, bytes with be[n]=1 of data written to bank[row]; be=0 -> no change, still granted and answered.
- Read on grant: data sampled at grant edge (before any same-cycle write to same word by another channel is impossible: one grant per bank per cycle).
- Response: every granted request (read or write) produces exactly one r_valid=1 on its own channel LATENCY cycles after the grant cycle. r_data = read word for reads, 32'h0 for writes; r_data=0 when r_valid=0. Per-channel responses in request order; back-to-back grants produce back-to-back r_valid.
- Response pipeline: per channel LATENCY-stage shift register of {valid, data}; no backpressure (protocol has none).
- Reset values: gnt=0 (comb, no req), r_valid=0, r_data=0, memory all-zero, pointers 0.
- clear_i=1: pipeline valids dropped (no r_valid for in-flight requests), pointers to 0, memory retained; requests in a clear cycle are still arbitrated/granted and writes performed, but produce no response.
- Reset mid-operation: all in-flight responses lost, memory zeroed.
- req held without gnt: address/data may change (no stability requirement in this block); arbitration reevaluated each cycle.

Decomposition:
- hwpe_stream_package: add TCDM_WORD_BITS=32, TCDM_BE_BITS=4 constants if absent.
- Sub-module hwpe_stream_tcdm_rr_arbiter (one per bank): NB_CHAN req vector in, one-hot gnt out, internal pointer, clear_i. Memory and response pipeline stay in top.

Test Plan:
- Single channel write 0xDEADBEEF to add 0x0000_0010 be=4'hF, then read same address -> both granted same cycle, r_valid at +LATENCY each, read r_data=0xDEADBEEF, write r_data=0.
- Byte enables: word=0x11223344, write 0xAABBCCDD be=4'b0101 -> read returns 0x11BB33DD.
- Conflict: ch0 and ch1 both read bank 0 every cycle for 4 cycles -> gnt alternates ch0,ch1,ch0,ch1; each gets two r_valids at grant+LATENCY.
- No conflict: ch0 add 0x0, ch1 add 0x4 (different banks) simultaneously -> both gnt=1 same cycle, both r_valid same cycle.
- Aliasing: write add 0x400 (NB_BANKS=4,NB_WORDS=64) then read add 0x0 -> same word returned.
- clear_i pulsed one cycle after a granted read (LATENCY=2) -> no r_valid for it; next ch1/ch0 contention grants ch0 first; rst_ni low mid-burst -> r_valid=0 immediately, subsequent reads return 0.

Source files
------------

// File: rtl/hwpe_stream_tcdm_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_tcdm_responder_pkg
// Brief    : Shared constants, response type and byte-merge helper for the
//            TCDM responder.
// Revision : 1.0
// ============================================================================
package hwpe_stream_tcdm_responder_pkg;

  localparam int TCDM_WORD_BITS = 32;
  localparam int TCDM_BE_BITS   = 4;

  typedef struct packed {
    logic                      valid;
    logic [TCDM_WORD_BITS-1:0] data;
  } resp_t;

  function automatic logic [TCDM_WORD_BITS-1:0] be_merge(
    input logic [TCDM_WORD_BITS-1:0] old_word,
    input logic [TCDM_WORD_BITS-1:0] new_word,
    input logic [TCDM_BE_BITS-1:0]   be
  );
    logic [TCDM_WORD_BITS-1:0] res;
    res = old_word;
    for (int n = 0; n < TCDM_BE_BITS; n++) begin
      if (be[n]) res[8*n +: 8] = new_word[8*n +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_tcdm_rr_arbiter
// Brief    : Combinational round-robin arbiter for one bank; one-hot grant.
// Revision : 1.0
// ============================================================================
module hwpe_stream_tcdm_rr_arbiter #(
  parameter int NB_CHAN = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic [NB_CHAN-1:0] req,
  output logic [NB_CHAN-1:0] gnt
);

  localparam int PTR_W = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_next;

  // Search starts at the pointer and wraps; the first requester found wins.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt      = '0;
    ptr_next = ptr_q;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NB_CHAN; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % NB_CHAN);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_next = PTR_W'((int'(idx) + 1) % NB_CHAN);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (clear_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hwpe_stream_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module   : hwpe_stream_tcdm_responder
// Brief    : Multi-port TCDM responder: word-interleaved flop banks with
//            per-bank round-robin arbitration and fixed-latency responses.
// Revision : 1.0
// ============================================================================
module hwpe_stream_tcdm_responder
  import hwpe_stream_tcdm_responder_pkg::*;
#(
  parameter int NB_CHAN  = 2,
  parameter int NB_BANKS = 4,
  parameter int NB_WORDS = 64,
  parameter int LATENCY  = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clear_i,
  input  logic [NB_CHAN-1:0]                     tcdm_req,
  input  logic [NB_CHAN-1:0][31:0]               tcdm_add,
  input  logic [NB_CHAN-1:0]                     tcdm_we_n,
  input  logic [NB_CHAN-1:0][TCDM_BE_BITS-1:0]   tcdm_be,
  input  logic [NB_CHAN-1:0][TCDM_WORD_BITS-1:0] tcdm_data,
  output logic [NB_CHAN-1:0]                     tcdm_gnt,
  output logic [NB_CHAN-1:0][TCDM_WORD_BITS-1:0] tcdm_r_data,
  output logic [NB_CHAN-1:0]                     tcdm_r_valid
);

  localparam int BANK_BITS = $clog2(NB_BANKS);
  localparam int ROW_BITS  = $clog2(NB_WORDS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_W     = (ROW_BITS > 0) ? ROW_BITS : 1;

  logic [NB_CHAN-1:0][BANK_W-1:0]         bank_sel;
  logic [NB_CHAN-1:0][ROW_W-1:0]          row_sel;
  logic [NB_CHAN-1:0][TCDM_WORD_BITS-1:0] rd_data;
  logic [NB_BANKS-1:0][NB_CHAN-1:0]       bank_req;
  logic [NB_BANKS-1:0][NB_CHAN-1:0]       bank_gnt;

  logic [NB_BANKS-1:0]                     wr_en;
  logic [NB_BANKS-1:0][ROW_W-1:0]          wr_row;
  logic [NB_BANKS-1:0][TCDM_WORD_BITS-1:0] wr_data;
  logic [NB_BANKS-1:0][TCDM_BE_BITS-1:0]   wr_be;

  logic [TCDM_WORD_BITS-1:0] mem_q  [NB_BANKS][NB_WORDS];
  resp_t                     pipe_q [NB_CHAN][LATENCY];

  // Offset and high address bits are don't-care (aliasing by design).
  logic unused_add;
  assign unused_add = ^tcdm_add;

  for (genvar c = 0; c < NB_CHAN; c++) begin : g_dec
    if (BANK_BITS > 0) begin : g_bank_field
      assign bank_sel[c] = tcdm_add[c][2 +: BANK_W];
    end else begin : g_single_bank
      assign bank_sel[c] = '0;
    end
    if (ROW_BITS > 0) begin : g_row_field
      assign row_sel[c] = tcdm_add[c][2+BANK_BITS +: ROW_W];
    end else begin : g_single_row
      assign row_sel[c] = '0;
    end
    assign rd_data[c] = mem_q[bank_sel[c]][row_sel[c]];
  end

  always_comb begin
    bank_req = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int c = 0; c < NB_CHAN; c++) begin
        bank_req[b][c] = tcdm_req[c] && (int'(bank_sel[c]) == b);
      end
    end
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_arb
    hwpe_stream_tcdm_rr_arbiter #(
      .NB_CHAN (NB_CHAN)
    ) i_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .req     (bank_req[b]),
      .gnt     (bank_gnt[b])
    );
  end

  always_comb begin
    tcdm_gnt = '0;
    wr_en    = '0;
    wr_row   = '0;
    wr_data  = '0;
    wr_be    = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int c = 0; c < NB_CHAN; c++) begin
        if (bank_gnt[b][c]) begin
          tcdm_gnt[c] = 1'b1;
          if (!tcdm_we_n[c]) begin
            wr_en[b]   = 1'b1;
            wr_row[b]  = row_sel[c];
            wr_data[b] = tcdm_data[c];
            wr_be[b]   = tcdm_be[c];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NB_BANKS; b++) begin
        for (int w = 0; w < NB_WORDS; w++) begin
          mem_q[b][w] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NB_BANKS; b++) begin
        if (wr_en[b]) begin
          mem_q[b][wr_row[b]] <= be_merge(mem_q[b][wr_row[b]], wr_data[b], wr_be[b]);
        end
      end
    end
  end

  // Invalid stages always carry zero data so r_data is clean when r_valid=0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CHAN; c++) begin
        for (int s = 0; s < LATENCY; s++) begin
          pipe_q[c][s] <= '0;
        end
      end
    end else if (clear_i) begin
      for (int c = 0; c < NB_CHAN; c++) begin
        for (int s = 0; s < LATENCY; s++) begin
          pipe_q[c][s] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NB_CHAN; c++) begin
        if (tcdm_gnt[c]) begin
          pipe_q[c][0] <= resp_t'{valid: 1'b1, data: (tcdm_we_n[c] ? rd_data[c] : '0)};
        end else begin
          pipe_q[c][0] <= '0;
        end
        for (int s = 1; s < LATENCY; s++) begin
          pipe_q[c][s] <= pipe_q[c][s-1];
        end
      end
    end
  end

  always_comb begin
    tcdm_r_valid = '0;
    tcdm_r_data  = '0;
    for (int c = 0; c < NB_CHAN; c++) begin
      tcdm_r_valid[c] = pipe_q[c][LATENCY-1].valid;
      tcdm_r_data[c]  = pipe_q[c][LATENCY-1].data;
    end
  end

endmodule
`default_nettype wire
